// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared encodings for the ALU issue stage: in_sel controls,
//                FSM state encoding, one-hot op names and the command record.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   // ALU input-latch control encodings
   localparam logic [2:0] IN_PERSIST = 3'b100;
   localparam logic [2:0] IN_LOAD    = 3'b010;
   localparam logic [2:0] IN_RESET   = 3'b001;

   // Issue FSM states (encoding is visible on the debug port)
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_EXEC = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   // One-hot operation selects
   localparam logic [6:0] OP_0 = 7'b1000000;
   localparam logic [6:0] OP_1 = 7'b0100000;
   localparam logic [6:0] OP_2 = 7'b0010000;
   localparam logic [6:0] OP_3 = 7'b0001000;
   localparam logic [6:0] OP_4 = 7'b0000100;
   localparam logic [6:0] OP_5 = 7'b0000010;
   localparam logic [6:0] OP_6 = 7'b0000001;

   // One queued command: operands plus operation
   typedef struct packed {
      logic [7:0] num1;
      logic [7:0] num2;
      logic [6:0] op;
   } cmd_t;

   // True when exactly one bit of the op select is set
   function automatic logic is_onehot(input logic [6:0] v);
      return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_fifo
//  Description : DEPTH-entry command FIFO with registered full/empty flags,
//                wrapping pointers and a separate occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  cmd_t                     wdata_i,
   input  logic                     pop_i,
   output cmd_t                     rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int              PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]  CNT_FULL = (PTR_W + 1)'(DEPTH);

   cmd_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic [PTR_W:0]   count_d;
   logic             full_q;
   logic             empty_q;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push_i && !full_q;
   assign pop_ok  = pop_i && !empty_q;

   // Next occupancy: push and pop together leave it unchanged
   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + CNT_ONE;
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - CNT_ONE;
      end
   end

   // Pointer, count and flag registers; flags come from the next count
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         full_q  <= (count_d == CNT_FULL);
         empty_q <= (count_d == '0);
      end
   end

   // Storage array; contents need no reset since empty gates every read
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_queue
//  Description : Buffers operand/op commands and sequences each one into the
//                ALU via the in_sel load/persist protocol, capturing the ALU
//                result after HOLD_CYCLES and returning it on a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_queue
   import alu_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int HOLD_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        on_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [7:0]  cmd_num1_i,
   input  logic [7:0]  cmd_num2_i,
   input  logic [6:0]  cmd_op_i,
   output logic        cmd_err_o,
   output logic [7:0]  num1_o,
   output logic [7:0]  num2_o,
   output logic [2:0]  in_sel_o,
   output logic [6:0]  out_sel_o,
   input  logic [7:0]  alu_out_i,
   output logic        res_valid_o,
   input  logic        res_ready_i,
   output logic [7:0]  res_data_o,
   output logic [6:0]  res_op_o,
   output logic [1:0]  state_o
);

   localparam int                   CNT_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0]     HOLD_VAL = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
   localparam int                   FCNT_W   = $clog2(DEPTH) + 1;
   localparam logic [FCNT_W-1:0]    FCNT_FULL = FCNT_W'(DEPTH);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              in_rst_q;
   logic [7:0]        num1_q, num2_q;
   logic [6:0]        out_sel_q;
   logic [7:0]        res_data_q;
   logic [6:0]        res_op_q;
   logic              cmd_err_q;

   logic              w_pop;
   logic              w_capture;
   logic              w_op_ok;
   logic              w_push;
   cmd_t              w_push_cmd;
   cmd_t              w_head;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [FCNT_W-1:0] w_fifo_count;

   assign w_op_ok    = is_onehot(cmd_op_i);
   assign w_push     = cmd_valid_i && !w_fifo_full && w_op_ok;
   assign w_push_cmd = '{num1: cmd_num1_i, num2: cmd_num2_i, op: cmd_op_i};

   alu_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_push),
      .wdata_i (w_push_cmd),
      .pop_i   (w_pop),
      .rdata_o (w_head),
      .full_o  (w_fifo_full),
      .empty_o (w_fifo_empty),
      .count_o (w_fifo_count)
   );

   // Issue sequencing: a new LOAD is gated by on_i; a started command always completes
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      w_pop     = 1'b0;
      w_capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (on_i && !w_fifo_empty) begin
               state_d = ST_LOAD;
               w_pop   = 1'b1;
            end
         end
         ST_LOAD: begin
            state_d = ST_EXEC;
            cnt_d   = HOLD_VAL;
         end
         ST_EXEC: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d   = ST_DONE;
               w_capture = 1'b1;
            end
         end
         ST_DONE: begin
            if (res_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, hold counter and the post-reset in_sel flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         in_rst_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         in_rst_q <= 1'b0;
      end
   end

   // Issue registers take the FIFO head on the pop and hold it until the next one
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         num1_q    <= '0;
         num2_q    <= '0;
         out_sel_q <= '0;
      end else if (w_pop) begin
         num1_q    <= w_head.num1;
         num2_q    <= w_head.num2;
         out_sel_q <= w_head.op;
      end
   end

   // Result capture at the end of the settle window; held through DONE
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         res_data_q <= '0;
         res_op_q   <= '0;
      end else if (w_capture) begin
         res_data_q <= alu_out_i;
         res_op_q   <= out_sel_q;
      end
   end

   // Single-cycle error pulse for a handshaken command with a bad op select
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cmd_err_q <= 1'b0;
      end else begin
         cmd_err_q <= cmd_valid_i && !w_fifo_full && !w_op_ok;
      end
   end

   // Full flag and occupancy count must agree
   a_full_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
      w_fifo_full == (w_fifo_count == FCNT_FULL));

   assign cmd_ready_o = !w_fifo_full;
   assign cmd_err_o   = cmd_err_q;
   assign num1_o      = num1_q;
   assign num2_o      = num2_q;
   assign out_sel_o   = out_sel_q;
   assign in_sel_o    = in_rst_q ? IN_RESET :
                        (state_q == ST_LOAD) ? IN_LOAD : IN_PERSIST;
   assign res_valid_o = (state_q == ST_DONE);
   assign res_data_o  = res_data_q;
   assign res_op_o    = res_op_q;
   assign state_o     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_queue
//  Description : Self-checking bench for alu_issue_queue with a small ALU
//                environment model and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_queue;
   import alu_pkg::*;

   localparam int DEPTH = 4;
   localparam int HOLD  = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       on = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_num1 = 8'd0;
   logic [7:0] cmd_num2 = 8'd0;
   logic [6:0] cmd_op = 7'd0;
   logic       res_ready = 1'b0;
   logic       cmd_ready, cmd_err, res_valid;
   logic [7:0] num1, num2, res_data, alu_out;
   logic [2:0] in_sel;
   logic [6:0] out_sel, res_op;
   logic [1:0] state;

   always #5 clk = ~clk;

   alu_issue_queue #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
      .clk_i(clk), .rst_ni(rst_n), .on_i(on),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_num1_i(cmd_num1), .cmd_num2_i(cmd_num2), .cmd_op_i(cmd_op),
      .cmd_err_o(cmd_err), .num1_o(num1), .num2_o(num2),
      .in_sel_o(in_sel), .out_sel_o(out_sel), .alu_out_i(alu_out),
      .res_valid_o(res_valid), .res_ready_i(res_ready),
      .res_data_o(res_data), .res_op_o(res_op), .state_o(state)
   );

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [6:0] op);
      case (op)
         7'b1000000: return a + b;
         7'b0100000: return a - b;
         7'b0010000: return a & b;
         7'b0001000: return a | b;
         7'b0000100: return a ^ b;
         7'b0000010: return a;
         7'b0000001: return ~a;
         default:    return 8'h00;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ALU environment: latches on a load, output only settles HOLD-1 edges later
   logic [7:0] a_n1 = 8'd0, a_n2 = 8'd0;
   logic [6:0] a_op = 7'd0;
   int         a_s = 0;
   always @(posedge clk) begin
      if (in_sel == IN_LOAD) begin
         a_n1 <= num1; a_n2 <= num2; a_op <= out_sel; a_s <= 0;
      end else if (a_s < 1000) begin
         a_s <= a_s + 1;
      end
   end
   assign alu_out = (a_s >= HOLD - 1) ? alu_fn(a_n1, a_n2, a_op) : ~alu_fn(a_n1, a_n2, a_op);

   // Reference model: queue of accepted commands and the age of the one in flight
   typedef struct packed { bit [7:0] n1; bit [7:0] n2; bit [6:0] op; } mcmd_t;
   mcmd_t    m_q[$];
   mcmd_t    m_cur = '0;
   bit       m_busy = 1'b0;
   int       m_age = 0;
   bit [7:0] m_res = 8'd0;
   bit [6:0] m_res_op = 7'd0;
   bit       m_err = 1'b0;
   bit       m_in_rst = 1'b1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_cur = '0; m_busy = 1'b0; m_age = 0;
         m_res = 8'd0; m_res_op = 7'd0; m_err = 1'b0; m_in_rst = 1'b1;
      end else begin
         automatic bit was_ready = (m_q.size() < DEPTH);
         if (m_busy) begin
            if (m_age > HOLD) begin
               if (res_ready) m_busy = 1'b0;
            end else begin
               m_age++;
               if (m_age == HOLD + 1) begin
                  m_res    = alu_fn(m_cur.n1, m_cur.n2, m_cur.op);
                  m_res_op = m_cur.op;
               end
            end
         end else if (on && m_q.size() > 0) begin
            m_cur  = m_q.pop_front();
            m_busy = 1'b1;
            m_age  = 0;
         end
         m_err = 1'b0;
         if (cmd_valid && was_ready) begin
            if ($countones(cmd_op) == 1) m_q.push_back('{n1: cmd_num1, n2: cmd_num2, op: cmd_op});
            else                         m_err = 1'b1;
         end
         m_in_rst = 1'b0;
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      automatic logic [1:0] e_state = !m_busy ? 2'd0 : (m_age == 0) ? 2'd1 :
                                      (m_age <= HOLD) ? 2'd2 : 2'd3;
      automatic logic [2:0] e_insel = m_in_rst ? 3'b001 :
                                      (m_busy && m_age == 0) ? 3'b010 : 3'b100;
      chk("m_state",     32'(state),     32'(e_state));
      chk("m_in_sel",    32'(in_sel),    32'(e_insel));
      chk("m_num1",      32'(num1),      32'(m_cur.n1));
      chk("m_num2",      32'(num2),      32'(m_cur.n2));
      chk("m_out_sel",   32'(out_sel),   32'(m_cur.op));
      chk("m_res_valid", 32'(res_valid), 32'(m_busy && m_age > HOLD));
      chk("m_res_data",  32'(res_data),  32'(m_res));
      chk("m_res_op",    32'(res_op),    32'(m_res_op));
      chk("m_cmd_ready", 32'(cmd_ready), 32'(m_q.size() < DEPTH));
      chk("m_cmd_err",   32'(cmd_err),   32'(m_err));
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] n1, input logic [7:0] n2, input logic [6:0] op);
      cmd_valid = 1'b1; cmd_num1 = n1; cmd_num2 = n2; cmd_op = op;
      step();
      cmd_valid = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] fill_ops [5];
      int         times[$];
      logic [6:0] ops_seen[$];
      logic [7:0] held;
      fill_ops = '{OP_1, OP_2, OP_3, OP_4, OP_5};

      // Reset
      rst_n = 1'b0;
      repeat (3) step();
      chk("rst_in_sel",    32'(in_sel),    32'(3'b001));
      chk("rst_num1",      32'(num1),      32'(0));
      chk("rst_num2",      32'(num2),      32'(0));
      chk("rst_out_sel",   32'(out_sel),   32'(0));
      chk("rst_res_data",  32'(res_data),  32'(0));
      chk("rst_res_valid", 32'(res_valid), 32'(0));
      chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
      rst_n = 1'b1;
      step();
      chk("rel_in_sel", 32'(in_sel), 32'(3'b100));
      chk("rel_state",  32'(state),  32'(0));

      // Single op
      on = 1'b1; res_ready = 1'b1;
      push(8'h57, 8'h1A, OP_0);
      step();
      chk("one_load_in_sel", 32'(in_sel),  32'(3'b010));
      chk("one_load_num1",   32'(num1),    32'(8'h57));
      chk("one_load_num2",   32'(num2),    32'(8'h1A));
      chk("one_load_op",     32'(out_sel), 32'(OP_0));
      step();
      chk("one_exec_in_sel", 32'(in_sel), 32'(3'b100));
      step();
      chk("one_not_yet",     32'(res_valid), 32'(0));
      step();
      chk("one_res_valid",   32'(res_valid), 32'(1));
      chk("one_res_data",    32'(res_data),  32'(8'h71));
      chk("one_res_op",      32'(res_op),    32'(OP_0));
      repeat (3) step();

      // Fill with issue disabled, then drain
      on = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1;
         cmd_num1  = 8'(8'h10 * (i + 1));
         cmd_num2  = 8'(i + 3);
         cmd_op    = fill_ops[i];
         step();
         if (i == 3) chk("fill_ready_low", 32'(cmd_ready), 32'(0));
      end
      cmd_valid = 1'b0;
      chk("fill_still_full", 32'(cmd_ready), 32'(0));
      on = 1'b1;
      for (int c = 0; c < 60 && times.size() < 4; c++) begin
         step();
         if (res_valid) begin
            times.push_back(c);
            ops_seen.push_back(res_op);
         end
      end
      chk("drain_count", 32'(times.size()), 32'(4));
      for (int i = 0; i + 1 < times.size(); i++)
         chk("drain_spacing", 32'(times[i+1] - times[i]), 32'(3 + HOLD));
      for (int i = 0; i < ops_seen.size(); i++)
         chk("drain_order", 32'(ops_seen[i]), 32'(fill_ops[i]));
      repeat (3) step();

      // Invalid op
      push(8'h11, 8'h22, 7'b0000011);
      chk("err_pulse", 32'(cmd_err), 32'(1));
      step();
      chk("err_clear", 32'(cmd_err), 32'(0));
      repeat (3) begin
         step();
         chk("err_no_load", 32'(state),     32'(0));
         chk("err_ready",   32'(cmd_ready), 32'(1));
      end

      // Backpressure in DONE
      res_ready = 1'b0;
      push(8'hC3, 8'h3C, OP_5);
      push(8'h5A, 8'h00, OP_6);
      for (int c = 0; c < 20 && state != 2'd3; c++) step();
      chk("bp_done", 32'(state), 32'(3));
      held = res_data;
      chk("bp_value", 32'(held), 32'(8'hC3));
      repeat (6) begin
         step();
         chk("bp_state",  32'(state),    32'(3));
         chk("bp_stable", 32'(res_data), 32'(held));
         chk("bp_no_load", 32'(in_sel),  32'(3'b100));
      end
      res_ready = 1'b1;
      step();
      chk("bp_idle", 32'(state), 32'(0));
      step();
      chk("bp_next_load", 32'(state), 32'(1));
      chk("bp_next_num1", 32'(num1),  32'(8'h5A));
      repeat (8) step();

      // Reset during EXEC with two commands queued
      push(8'h01, 8'h02, OP_2);
      push(8'h03, 8'h04, OP_3);
      push(8'h05, 8'h06, OP_4);
      for (int c = 0; c < 10 && state != 2'd2; c++) step();
      chk("mid_exec", 32'(state), 32'(2));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_state",  32'(state),     32'(0));
      chk("mid_rst_in_sel", 32'(in_sel),    32'(3'b001));
      chk("mid_rst_valid",  32'(res_valid), 32'(0));
      chk("mid_rst_num1",   32'(num1),      32'(0));
      chk("mid_rst_ready",  32'(cmd_ready), 32'(1));
      repeat (2) begin
         step();
         chk("mid_rst_hold", 32'(res_valid), 32'(0));
      end
      rst_n = 1'b1;
      step();
      repeat (6) begin
         step();
         chk("post_rst_idle",  32'(state),     32'(0));
         chk("post_rst_valid", 32'(res_valid), 32'(0));
      end

      // Randomized traffic
      for (int c = 0; c < 2000; c++) begin
         cmd_valid = ($urandom_range(0, 1) == 1);
         cmd_num1  = 8'($urandom);
         cmd_num2  = 8'($urandom);
         if ($urandom_range(0, 9) < 8) cmd_op = OP_0 >> $urandom_range(0, 6);
         else                          cmd_op = 7'($urandom);
         on        = ($urandom_range(0, 9) < 8);
         res_ready = ($urandom_range(0, 9) < 6);
         rst_n     = ($urandom_range(0, 599) != 0);
         step();
      end
      rst_n = 1'b1; cmd_valid = 1'b0; on = 1'b1; res_ready = 1'b1;
      repeat (30) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
